// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared constants and state encoding for serial_pattern_tx.
// Optional feature macro: SERIAL_TX_PARITY_EN (adds one even-parity bit after D0).
package serial_tx_pkg;

    localparam int unsigned DATA_W         = 8;
    localparam int unsigned CNT_W          = 4;
    localparam int unsigned FRAME_LEN_BASE = 10;
    localparam int unsigned FRAME_LEN_PAR  = 11;

`ifdef SERIAL_TX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int unsigned FRAME_LEN = PARITY_EN ? FRAME_LEN_PAR : FRAME_LEN_BASE;

    // Bit count at which DATAB is left: frame minus start, stop and zero-based offset.
    localparam int unsigned LAST_BIT = FRAME_LEN - 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_STARTB = 2'b01,
        ST_DATAB  = 2'b11,
        ST_STOPB  = 2'b10
    } state_e;

endpackage

// File: rtl/serial_pattern_tx_if.sv
// serial_pattern_tx_if: frame request / serial line bundle.
//   START, DATA          : requester -> transmitter
//   READY, X, DONE,
//   CurrentState         : transmitter -> downstream / requester
interface serial_pattern_tx_if;
    import serial_tx_pkg::*;

    logic              START;
    logic [DATA_W-1:0] DATA;
    logic              READY;
    logic              X;
    logic              DONE;
    logic [1:0]        CurrentState;

    modport master (
        output START, DATA,
        input  READY, X, DONE, CurrentState
    );

    modport slave (
        input  START, DATA,
        output READY, X, DONE, CurrentState
    );

endinterface

// File: rtl/serial_pattern_tx_shifter.sv
// tx_shifter: payload shift register, data-bit counter and parity accumulator.
//   clk, rst_n   : clock, async active-low reset
//   load_i       : capture data_i, clear counter and parity
//   shift_i      : shift left one bit, count it, fold outgoing MSB into parity
//   data_i       : payload
//   cur_bit_o    : current MSB of the shift register
//   nxt_bit_o    : bit that becomes MSB after the next shift
//   par_o        : XOR of all bits shifted out so far in this frame
//   cnt_o        : number of shifts since load
module tx_shifter
    import serial_tx_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [DATA_W-1:0] data_i,
    output logic             cur_bit_o,
    output logic             nxt_bit_o,
    output logic             par_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              par_q, par_d;

    // Next-state: load has priority over shift.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        if (load_i) begin
            shift_d = data_i;
            cnt_d   = '0;
            par_d   = 1'b0;
        end else if (shift_i) begin
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
            cnt_d   = cnt_q + CNT_W'(1);
            par_d   = par_q ^ shift_q[DATA_W-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
        end
    end

    assign cur_bit_o = shift_q[DATA_W-1];
    assign nxt_bit_o = shift_q[DATA_W-2];
    assign par_o     = par_q;
    assign cnt_o     = cnt_q;

endmodule

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: frames an 8-bit payload onto serial line X as
//   start(1) D7..D0 [parity] stop(0), followed by at least one IDLE cycle (X=0).
// Optional feature macro: SERIAL_TX_PARITY_EN (even parity bit after D0).
//   CLOCK        : sole clock
//   RESET        : async active-low reset
//   bus (slave)  : START/DATA request in; READY, X, DONE, CurrentState out
// X, READY and DONE are flops loaded from the next-state decode, so they
// always agree with CurrentState and have no combinational input path.
module serial_pattern_tx
    import serial_tx_pkg::*;
(
    input  logic         CLOCK,
    input  logic         RESET,
    serial_pattern_tx_if.slave bus
);

    state_e           state_q, state_d;
    logic             x_q, x_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             load_c;
    logic             shift_c;
    logic             cur_bit;
    logic             nxt_bit;
    logic             par_acc;
    logic [CNT_W-1:0] bit_cnt;

    tx_shifter u_shifter (
        .clk       (CLOCK),
        .rst_n     (RESET),
        .load_i    (load_c),
        .shift_i   (shift_c),
        .data_i    (bus.DATA),
        .cur_bit_o (cur_bit),
        .nxt_bit_o (nxt_bit),
        .par_o     (par_acc),
        .cnt_o     (bit_cnt)
    );

    // Next state plus the value each output takes in that next state.
    always_comb begin
        state_d = state_q;
        x_d     = 1'b0;
        done_d  = 1'b0;
        load_c  = 1'b0;
        shift_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    state_d = ST_STARTB;
                    load_c  = 1'b1;
                    x_d     = 1'b1;
                end
            end
            ST_STARTB: begin
                state_d = ST_DATAB;
                x_d     = cur_bit;
            end
            ST_DATAB: begin
                shift_c = 1'b1;
                if (bit_cnt == CNT_W'(LAST_BIT)) begin
                    state_d = ST_STOPB;
                    done_d  = 1'b1;
                end else if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                    // Only reachable with parity: D0 is on the line, parity follows.
                    x_d = par_acc ^ cur_bit;
                end else begin
                    x_d = nxt_bit;
                end
            end
            ST_STOPB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            x_q     <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign bus.X            = x_q;
    assign bus.READY        = ready_q;
    assign bus.DONE         = done_q;
    assign bus.CurrentState = state_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: scoreboard bench for serial_pattern_tx.
module tb_serial_pattern_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int FLEN   = 11;
    localparam int PERIOD = 12;
`else
    localparam int FLEN   = 10;
    localparam int PERIOD = 11;
`endif

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;

    serial_pattern_tx_if bus ();

    serial_pattern_tx dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic       x;
        logic       done;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   start_cyc[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;

    // Downstream three-consecutive-ones detector on X.
    logic [2:0] det_sh;
    logic       det;
    always @(posedge CLOCK or negedge RESET) begin
        if (!RESET) det_sh <= 3'b000;
        else        det_sh <= {det_sh[1:0], bus.X};
    end
    assign det = &det_sh;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle line content of one frame; parity bit given by hand.
    task automatic push_frame(input logic [7:0] d, input logic p);
        exp_t e;
        e = '{1'b1, 1'b0, 2'b01};
        exp_q.push_back(e);
        for (int i = 7; i >= 0; i--) begin
            e = '{d[i], 1'b0, 2'b11};
            exp_q.push_back(e);
        end
`ifdef SERIAL_TX_PARITY_EN
        e = '{p, 1'b0, 2'b11};
        exp_q.push_back(e);
`else
        if (p === 1'bx) $display("note: parity unknown");
`endif
        e = '{1'b0, 1'b1, 2'b10};
        exp_q.push_back(e);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.READY !== 1'b1 && n < 40) begin
            @(posedge CLOCK);
            #1;
            n++;
        end
        if (bus.READY !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_ready: got READY=%b expected 1 within 40 cycles", bus.READY);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic p);
        wait_ready();
        bus.START = 1'b1;
        bus.DATA  = d;
        push_frame(d, p);
        @(posedge CLOCK);
        #1;
        bus.START = 1'b0;
    endtask

    // Monitor: frame cycles (READY=0) pop the scoreboard, idle cycles must be quiet.
    always @(negedge CLOCK) begin
        exp_t e;
        cyc = cyc + 1;
        if (mon_en && RESET === 1'b1) begin
            if (bus.CurrentState === 2'b01) start_cyc.push_back(cyc);
            if (bus.READY !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame_bit: got X=%b state=%b expected IDLE", bus.X, bus.CurrentState);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_X",     32'(bus.X),            32'(e.x));
                    check("frame_DONE",  32'(bus.DONE),         32'(e.done));
                    check("frame_state", 32'(bus.CurrentState), 32'(e.st));
                end
            end else begin
                check("idle_X",     32'(bus.X),            32'd0);
                check("idle_DONE",  32'(bus.DONE),         32'd0);
                check("idle_state", 32'(bus.CurrentState), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int  run;
        int  max_run;
        bit  fired;
        int  base;

        bus.START = 1'b0;
        bus.DATA  = 8'h00;

        // Asynchronous reset takes effect without a clock edge.
        #2 RESET = 1'b0;
        #1;
        check("rst_state", 32'(bus.CurrentState), 32'd0);
        check("rst_X",     32'(bus.X),            32'd0);
        check("rst_READY", 32'(bus.READY),        32'd1);
        check("rst_DONE",  32'(bus.DONE),         32'd0);
        repeat (2) @(posedge CLOCK);
        #3;

        // A5 requested together with reset release: accepted on the first edge.
        RESET     = 1'b1;
        mon_en    = 1'b1;
        bus.START = 1'b1;
        bus.DATA  = 8'hA5;
        push_frame(8'hA5, 1'b0);
        @(posedge CLOCK);
        #1;
        bus.START = 1'b0;
        check("accept_first_edge", 32'(bus.CurrentState), 32'h1);
        repeat (FLEN - 1) @(posedge CLOCK);
        #1;
        check("a5_last_DONE",  32'(bus.DONE),  32'd1);
        check("a5_last_READY", 32'(bus.READY), 32'd0);
        @(posedge CLOCK);
        #1;
        check("a5_after_READY", 32'(bus.READY), 32'd1);
        check("a5_after_DONE",  32'(bus.DONE),  32'd0);

        // FF: nine consecutive ones, detector fires.
        send(8'hFF, 1'b0);
        run = 0; max_run = 0; fired = 1'b0;
        for (int i = 0; i < FLEN + 2; i++) begin
            @(negedge CLOCK);
            run = (bus.X === 1'b1) ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (det === 1'b1) fired = 1'b1;
        end
        check("ff_max_run", 32'(max_run), 32'd9);
        check("ff_det",     32'(fired),   32'd1);

        // 81 frame with START/DATA disturbed mid-frame: no effect, no second frame.
        wait_ready();
        bus.START = 1'b1;
        bus.DATA  = 8'h81;
        push_frame(8'h81, 1'b0);
        @(posedge CLOCK);
        #1;
        bus.START = 1'b0;
        bus.DATA  = 8'h3C;
        repeat (4) @(posedge CLOCK);
        #1;
        bus.START = 1'b1;
        bus.DATA  = 8'h00;
        @(posedge CLOCK);
        #1;
        bus.START = 1'b0;
        fired = 1'b0;
        for (int i = 0; i < FLEN + 4; i++) begin
            @(negedge CLOCK);
            if (det === 1'b1) fired = 1'b1;
        end
        check("81_det_quiet", 32'(fired),         32'd0);
        check("81_no_second", 32'(exp_q.size()),  32'd0);

        // START held high: back-to-back 81 frames.
        wait_ready();
        base = start_cyc.size();
        for (int k = 0; k < 3; k++) push_frame(8'h81, 1'b0);
        bus.START = 1'b1;
        bus.DATA  = 8'h81;
        @(posedge CLOCK);
        repeat (2 * PERIOD) @(posedge CLOCK);
        #1;
        bus.START = 1'b0;
        repeat (PERIOD + 2) @(posedge CLOCK);
        #1;
        check("held_frames", 32'(start_cyc.size() - base), 32'd3);
        if (start_cyc.size() >= base + 3) begin
            check("held_period0", 32'(start_cyc[base+1] - start_cyc[base]),   32'(PERIOD));
            check("held_period1", 32'(start_cyc[base+2] - start_cyc[base+1]), 32'(PERIOD));
        end

        // Reset while D4 is on the line, then a fresh frame.
        wait_ready();
        bus.START = 1'b1;
        bus.DATA  = 8'h3C;
        push_frame(8'h3C, 1'b0);
        @(posedge CLOCK);
        #1;
        bus.START = 1'b0;
        repeat (4) @(posedge CLOCK);
        #2;
        RESET = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_state", 32'(bus.CurrentState), 32'd0);
        check("midrst_X",     32'(bus.X),            32'd0);
        check("midrst_READY", 32'(bus.READY),        32'd1);
        check("midrst_DONE",  32'(bus.DONE),         32'd0);
        repeat (3) @(posedge CLOCK);
        #3;
        RESET     = 1'b1;
        bus.START = 1'b1;
        bus.DATA  = 8'h5A;
        push_frame(8'h5A, 1'b0);
        @(posedge CLOCK);
        #1;
        bus.START = 1'b0;

        // 07: odd weight, parity bit 1 when enabled.
        send(8'h07, 1'b1);

        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 50) begin
                @(posedge CLOCK);
                n++;
            end
        end
        repeat (3) @(posedge CLOCK);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("end_READY",   32'(bus.READY),    32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
